// File: rtl/cr16_uart_loader.sv
// -----------------------------------------------------------------------------
// cr16_uart_loader
//   Program loader for the CR16 top level. Receives 8N1 UART bytes, packs
//   byte pairs (high byte first) into 16-bit words and writes them to
//   consecutive BRAM addresses. CR16 is held in reset until the whole image
//   has been written.
//
//   Optional feature macro: CR16_LOADER_CHECKSUM_EN
//     When defined, a 16-bit running sum of all written words is compared
//     with two trailing bytes (hi, lo). A mismatch parks the loader in an
//     error state with O_CHECKSUM_ERROR set. When undefined, O_CHECKSUM_ERROR
//     is tied low and DONE follows the last write directly.
//
// Ports
//   I_CLK               clock
//   I_NRESET            asynchronous active-low reset
//   I_UART_RX           serial input, idle high, asynchronous to I_CLK
//   I_START             one-cycle pulse restarting a load
//   O_MEM_DATA          BRAM write data {hi, lo}
//   O_MEM_ADDRESS       BRAM write address (wraps modulo 2^P_ADDRESS_WIDTH)
//   O_MEM_WRITE_ENABLE  BRAM write strobe, one cycle per word
//   O_CPU_NRESET        CR16 reset, released only when the image is loaded
//   O_DONE              image fully loaded (and checked)
//   O_FRAME_ERROR       sticky: a byte arrived with a zero stop bit
//   O_CHECKSUM_ERROR    checksum mismatch (feature macro only)
// -----------------------------------------------------------------------------
module cr16_uart_loader #(
  parameter int P_CLKS_PER_BIT  = 434,
  parameter int P_ADDRESS_WIDTH = 10,
  parameter int P_START_ADDRESS = 0,
  parameter int P_WORD_COUNT    = 1024
) (
  input  logic                       I_CLK,
  input  logic                       I_NRESET,
  input  logic                       I_UART_RX,
  input  logic                       I_START,
  output logic [15:0]                O_MEM_DATA,
  output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS,
  output logic                       O_MEM_WRITE_ENABLE,
  output logic                       O_CPU_NRESET,
  output logic                       O_DONE,
  output logic                       O_FRAME_ERROR,
  output logic                       O_CHECKSUM_ERROR
);

  localparam int CNT_W = $clog2(P_CLKS_PER_BIT);
  localparam int IDX_W = (P_WORD_COUNT > 1) ? $clog2(P_WORD_COUNT) : 1;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(P_CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(P_CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(P_WORD_COUNT - 1);
  localparam logic [P_ADDRESS_WIDTH-1:0] START_ADDR = P_ADDRESS_WIDTH'(P_START_ADDRESS);

  // ---------------------------------------------------------------------------
  // RX synchronizer and falling-edge detector
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= I_UART_RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------------------------------------------------------------------
  // UART byte receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t        rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]       rx_bit, rx_bit_n;
  logic [7:0]       rx_shift, rx_shift_n;
  logic             byte_ok;   // stop-bit sample cycle, stop bit good
  logic             byte_bad;  // stop-bit sample cycle, stop bit zero

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 1'b1;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    byte_ok    = 1'b0;
    byte_bad   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_sync) rx_state_n = RX_START;
      end
      RX_START: begin
        // Line back high at half a bit means the edge was a glitch.
        if (rx_cnt == HALF_M1) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == FULL_M1) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        // Return to idle at the stop-bit centre so the next start edge is seen.
        if (rx_cnt == FULL_M1) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
          byte_ok    = rx_sync;
          byte_bad   = !rx_sync;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else if (I_START) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    L_HI,
    L_LO,
    L_WRITE,
    L_CHECK_HI,
    L_CHECK_LO,
    L_CHECK,
    L_DONE,
    L_ERROR
  } ld_state_t;

  ld_state_t                  st, st_n;
  logic [IDX_W-1:0]           idx, idx_n;
  logic [7:0]                 hi_byte, hi_n;
  logic [15:0]                data_n;
  logic [P_ADDRESS_WIDTH-1:0] addr_n;
  logic                       we_n;
  logic                       ferr_n;
  logic                       done_n;

`ifdef CR16_LOADER_CHECKSUM_EN
  logic [15:0] sum, sum_n;
  logic [7:0]  lo_byte, lo_n;
  logic        cerr_n;
`endif

  always_comb begin
    st_n   = st;
    idx_n  = idx;
    hi_n   = hi_byte;
    data_n = O_MEM_DATA;
    addr_n = O_MEM_ADDRESS;
    we_n   = 1'b0;
    ferr_n = O_FRAME_ERROR | byte_bad;
`ifdef CR16_LOADER_CHECKSUM_EN
    sum_n  = sum;
    lo_n   = lo_byte;
`endif
    case (st)
      L_HI: begin
        if (byte_ok) begin
          hi_n = rx_shift;
          st_n = L_LO;
        end
      end
      L_LO: begin
        // Strobe, data and address are registered together on entry to WRITE.
        if (byte_ok) begin
          st_n   = L_WRITE;
          we_n   = 1'b1;
          data_n = {hi_byte, rx_shift};
          addr_n = START_ADDR + P_ADDRESS_WIDTH'(idx);
        end
      end
      L_WRITE: begin
`ifdef CR16_LOADER_CHECKSUM_EN
        sum_n = sum + O_MEM_DATA;
`endif
        if (idx == IDX_LAST) begin
`ifdef CR16_LOADER_CHECKSUM_EN
          st_n = L_CHECK_HI;
`else
          st_n = L_DONE;
`endif
        end else begin
          idx_n = idx + 1'b1;
          st_n  = L_HI;
        end
      end
`ifdef CR16_LOADER_CHECKSUM_EN
      L_CHECK_HI: begin
        if (byte_ok) begin
          hi_n = rx_shift;
          st_n = L_CHECK_LO;
        end
      end
      L_CHECK_LO: begin
        if (byte_ok) begin
          lo_n = rx_shift;
          st_n = L_CHECK;
        end
      end
      L_CHECK: st_n = ({hi_byte, lo_byte} == sum) ? L_DONE : L_ERROR;
      L_ERROR: st_n = L_ERROR;
`endif
      L_DONE: st_n = L_DONE;
      default: st_n = L_HI;
    endcase

    // Restart overrides everything, including a byte completing this cycle.
    if (I_START) begin
      st_n   = L_HI;
      idx_n  = '0;
      we_n   = 1'b0;
      ferr_n = 1'b0;
`ifdef CR16_LOADER_CHECKSUM_EN
      sum_n  = '0;
`endif
    end

    done_n = (st_n == L_DONE);
`ifdef CR16_LOADER_CHECKSUM_EN
    cerr_n = (st_n == L_ERROR);
`endif
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      st                 <= L_HI;
      idx                <= '0;
      hi_byte            <= '0;
      O_MEM_DATA         <= '0;
      O_MEM_ADDRESS      <= '0;
      O_MEM_WRITE_ENABLE <= 1'b0;
      O_CPU_NRESET       <= 1'b0;
      O_DONE             <= 1'b0;
      O_FRAME_ERROR      <= 1'b0;
    end else begin
      st                 <= st_n;
      idx                <= idx_n;
      hi_byte            <= hi_n;
      O_MEM_DATA         <= data_n;
      O_MEM_ADDRESS      <= addr_n;
      O_MEM_WRITE_ENABLE <= we_n;
      O_CPU_NRESET       <= done_n;
      O_DONE             <= done_n;
      O_FRAME_ERROR      <= ferr_n;
    end
  end

`ifdef CR16_LOADER_CHECKSUM_EN
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      sum              <= '0;
      lo_byte          <= '0;
      O_CHECKSUM_ERROR <= 1'b0;
    end else begin
      sum              <= sum_n;
      lo_byte          <= lo_n;
      O_CHECKSUM_ERROR <= cerr_n;
    end
  end
`else
  assign O_CHECKSUM_ERROR = 1'b0;
`endif

endmodule

// File: tb/tb_cr16_uart_loader.sv
module tb_cr16_uart_loader;

  localparam int CPB     = 4;
  localparam int AW      = 10;
  localparam int WC      = 3;
  localparam int START_A = 1020;
  localparam int START_B = 1022;
`ifdef CR16_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   data_a, data_b;
  logic [AW-1:0] addr_a, addr_b;
  logic          we_a, we_b, cpu_a, cpu_b, done_a, done_b;
  logic          ferr_a, ferr_b, cerr_a, cerr_b;

  always #5 clk = ~clk;

  cr16_uart_loader #(
    .P_CLKS_PER_BIT(CPB), .P_ADDRESS_WIDTH(AW),
    .P_START_ADDRESS(START_A), .P_WORD_COUNT(WC)
  ) dut_a (
    .I_CLK(clk), .I_NRESET(rst_n), .I_UART_RX(rx), .I_START(start),
    .O_MEM_DATA(data_a), .O_MEM_ADDRESS(addr_a), .O_MEM_WRITE_ENABLE(we_a),
    .O_CPU_NRESET(cpu_a), .O_DONE(done_a), .O_FRAME_ERROR(ferr_a),
    .O_CHECKSUM_ERROR(cerr_a)
  );

  cr16_uart_loader #(
    .P_CLKS_PER_BIT(CPB), .P_ADDRESS_WIDTH(AW),
    .P_START_ADDRESS(START_B), .P_WORD_COUNT(WC)
  ) dut_b (
    .I_CLK(clk), .I_NRESET(rst_n), .I_UART_RX(rx), .I_START(start),
    .O_MEM_DATA(data_b), .O_MEM_ADDRESS(addr_b), .O_MEM_WRITE_ENABLE(we_b),
    .O_CPU_NRESET(cpu_b), .O_DONE(done_b), .O_FRAME_ERROR(ferr_b),
    .O_CHECKSUM_ERROR(cerr_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (transaction level) ----------------
  typedef enum int {PH_LOAD, PH_CHECK, PH_DONE, PH_ERROR} phase_t;
  phase_t      m_phase;
  int          m_idx;
  bit          m_have_hi;
  logic [7:0]  m_hi;
  logic [15:0] m_sum;
  bit          m_ferr;
  int          exp_idx[$];
  logic [15:0] exp_data[$];
  bit          settled = 1'b0;

  function automatic void model_clear(input bit clear_queue);
    m_phase   = PH_LOAD;
    m_idx     = 0;
    m_have_hi = 1'b0;
    m_sum     = '0;
    m_ferr    = 1'b0;
    if (clear_queue) begin
      exp_idx.delete();
      exp_data.delete();
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit ok);
    logic [15:0] w;
    if (!ok) begin
      m_ferr = 1'b1;
      return;
    end
    if (m_phase == PH_DONE || m_phase == PH_ERROR) return;
    if (!m_have_hi) begin
      m_hi      = b;
      m_have_hi = 1'b1;
      return;
    end
    m_have_hi = 1'b0;
    w = {m_hi, b};
    if (m_phase == PH_LOAD) begin
      exp_idx.push_back(m_idx);
      exp_data.push_back(w);
      m_sum = m_sum + w;
      m_idx++;
      if (m_idx == WC) m_phase = CK ? PH_CHECK : PH_DONE;
    end else begin
      m_phase = (w == m_sum) ? PH_DONE : PH_ERROR;
    end
  endfunction

  // ---------------- compare process ----------------
  int          cyc = 0;
  int          last_we_cyc = 0;
  int          done_rise_cyc = 0;
  logic        done_prev = 1'b0;
  logic [15:0] log_data[$];
  int          log_addr_a[$];
  int          log_addr_b[$];

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (we_a || we_b) begin
        chk("we_a", int'(we_a), 1);
        chk("we_b", int'(we_b), 1);
        log_data.push_back(data_a);
        log_addr_a.push_back(int'(addr_a));
        log_addr_b.push_back(int'(addr_b));
        last_we_cyc = cyc;
        chk("write_expected", int'(exp_data.size() > 0), 1);
        if (exp_data.size() > 0) begin
          chk("data_a", int'(data_a), int'(exp_data[0]));
          chk("data_b", int'(data_b), int'(exp_data[0]));
          chk("addr_a", int'(addr_a), (START_A + exp_idx[0]) % (1 << AW));
          chk("addr_b", int'(addr_b), (START_B + exp_idx[0]) % (1 << AW));
          void'(exp_data.pop_front());
          void'(exp_idx.pop_front());
        end
      end
      if (done_a && !done_prev) done_rise_cyc = cyc;
      if (settled) begin
        chk("done_a", int'(done_a), int'(m_phase == PH_DONE));
        chk("cpu_nreset_a", int'(cpu_a), int'(m_phase == PH_DONE));
        chk("done_b", int'(done_b), int'(m_phase == PH_DONE));
        chk("cpu_nreset_b", int'(cpu_b), int'(m_phase == PH_DONE));
        chk("frame_error", int'(ferr_a), int'(m_ferr));
        chk("checksum_error", int'(cerr_a), int'(m_phase == PH_ERROR));
      end
    end
    done_prev = done_a;
  end

  // ---------------- stimulus ----------------
  task automatic drive_bit(input logic v);
    @(posedge clk);
    #1 rx = v;
    repeat (CPB - 1) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    settled = 1'b0;
    model_byte(b, ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(ok);
    @(posedge clk);
    #1 rx = 1'b1;
    repeat (4 + $urandom_range(0, 3)) @(posedge clk);
    #1 settled = 1'b1;
  endtask

  task automatic glitch(input int n);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (n) @(posedge clk);
    #1 rx = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic pulse_start();
    settled = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    model_clear(1'b0);
    repeat (2) @(posedge clk);
    #1 settled = 1'b1;
  endtask

  task automatic send_image();
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
  endtask

  task automatic check_first_write(input string nm, input int base);
    chk({nm, "_logged"}, int'(log_data.size() > base), 1);
    if (log_data.size() > base) begin
      chk({nm, "_data"}, int'(log_data[base]), 16'h1234);
      chk({nm, "_addr"}, log_addr_a[base], START_A);
    end
  endtask

  initial begin
    int base;
    model_clear(1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", int'(data_a), 0);
    chk("rst_addr", int'(addr_a), 0);
    chk("rst_we", int'(we_a), 0);
    chk("rst_cpu", int'(cpu_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_ferr", int'(ferr_a), 0);
    chk("rst_cerr", int'(cerr_a), 0);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 settled = 1'b1;

    // Directed image with wrap on the second instance.
    base = log_data.size();
    send_image();
`ifdef CR16_LOADER_CHECKSUM_EN
    send_byte(8'hBE, 1'b1); send_byte(8'h02, 1'b1);
    chk("ck_done_lit", int'(done_a), 1);
`else
    chk("done_delay_lit", done_rise_cyc - last_we_cyc, 1);
`endif
    chk("img_count_lit", log_data.size() - base, 3);
    if (log_data.size() - base == 3) begin
      chk("w0_data_lit", int'(log_data[base]), 16'h1234);
      chk("w1_data_lit", int'(log_data[base+1]), 16'hABCD);
      chk("w2_data_lit", int'(log_data[base+2]), 16'h0001);
      chk("w0_addr_a_lit", log_addr_a[base], 1020);
      chk("w2_addr_a_lit", log_addr_a[base+2], 1022);
      chk("w1_addr_b_lit", log_addr_b[base+1], 1023);
      chk("w2_addr_b_lit", log_addr_b[base+2], 0);
    end

    // Glitch followed by a real byte.
    pulse_start();
    base = log_data.size();
    glitch(2);
    send_image();
    check_first_write("glitch", base);

    // Frame error leaves the FSM untouched.
    pulse_start();
    base = log_data.size();
    send_byte(8'h55, 1'b0);
    chk("ferr_lit", int'(ferr_a), 1);
    chk("ferr_no_write", log_data.size() - base, 0);
    send_image();
    check_first_write("after_ferr", base);

    // Restart mid-image drops the partial pair.
    pulse_start();
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'hAB, 1'b1);
    pulse_start();
    base = log_data.size();
    send_image();
    check_first_write("restart", base);

`ifdef CR16_LOADER_CHECKSUM_EN
    pulse_start();
    send_image();
    send_byte(8'hBE, 1'b1); send_byte(8'h03, 1'b1);
    chk("cerr_lit", int'(cerr_a), 1);
    chk("cerr_cpu_lit", int'(cpu_a), 0);
    pulse_start();
    chk("cerr_clear_lit", int'(cerr_a), 0);
`endif

    // Reset in the middle of a byte abandons the load.
    pulse_start();
    send_byte(8'h12, 1'b1);
    settled = 1'b0;
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
    #1 rst_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    chk("midrst_we", int'(we_a), 0);
    chk("midrst_done", int'(done_a), 0);
    chk("midrst_addr", int'(addr_a), 0);
    model_clear(1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 settled = 1'b1;
    base = log_data.size();
    send_image();
    check_first_write("after_reset", base);

    // Randomized images with glitches, frame errors and checksum faults.
    for (int it = 0; it < 12; it++) begin
      logic [15:0] w;
      logic [15:0] sum;
      pulse_start();
      sum = '0;
      for (int k = 0; k < WC; k++) begin
        w = 16'($urandom);
        sum = sum + w;
        if ($urandom_range(0, 3) == 0) glitch($urandom_range(1, 2));
        if ($urandom_range(0, 4) == 0) send_byte(8'($urandom), 1'b0);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
      end
      if (CK) begin
        if ($urandom_range(0, 2) == 0) sum = sum ^ 16'(1 << $urandom_range(0, 15));
        send_byte(sum[15:8], 1'b1);
        send_byte(sum[7:0], 1'b1);
      end
      repeat (4) @(posedge clk);
    end

    chk("pending_writes", exp_data.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
